// File: rtl/bananachine_pkg.sv
// Shared types and encodings for the bananachine multicycle control unit:
// FSM states, the registered strobe bundle, opcode/ALU/flag/condition constants.
package bananachine_pkg;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        FETCH_WAIT = 4'd1,
        DECODE     = 4'd2,
        EXECUTE    = 4'd3,
        LD_ADDR    = 4'd4,
        LD_WAIT    = 4'd5,
        LD_WB      = 4'd6,
        STORE      = 4'd7,
        BRANCH     = 4'd8
    } state_t;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic       pc_src;
        logic       mem_addr_src;
        logic       wren_a;
        logic       reg_write;
        logic [1:0] reg_write_src;
        logic       alu_A_src;
        logic       alu_B_src;
        logic [5:0] alu_cont;
        logic       psr_en;
    } ctrl_t;

    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_SPECIAL = 4'b0100;
    localparam logic [3:0] OP_ADDI    = 4'b0101;
    localparam logic [3:0] OP_SUBI    = 4'b1001;
    localparam logic [3:0] OP_CMPI    = 4'b1011;
    localparam logic [3:0] OP_BCOND   = 4'b1100;
    localparam logic [3:0] OP_MOVI    = 4'b1101;

    localparam logic [3:0] EXT_LOAD   = 4'b0000;
    localparam logic [3:0] EXT_STOR   = 4'b0100;
    localparam logic [3:0] EXT_JAL    = 4'b1000;
    localparam logic [3:0] EXT_JCOND  = 4'b1100;
    localparam logic [3:0] EXT_ADD    = 4'b0101;
    localparam logic [3:0] EXT_SUB    = 4'b1001;
    localparam logic [3:0] EXT_CMP    = 4'b1011;

    localparam logic [5:0] ALU_NOP    = 6'b000000;
    localparam logic [5:0] ALU_ADD    = 6'b000101;
    localparam logic [5:0] ALU_PASSB  = 6'b111111;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 2;
    localparam int FLAG_F = 5;
    localparam int FLAG_Z = 6;
    localparam int FLAG_N = 7;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    // R-type ext codes with no ALU operation behind them execute as NOPs.
    function automatic logic rtype_defined(input logic [3:0] ext);
        return !(ext inside {4'b0000, 4'b0100, 4'b1000, 4'b1100, 4'b1111});
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: decodes a 4-bit condition code against the
// PSR flags and reports whether the branch is taken.
import bananachine_pkg::*;

module cond_eval #(
    parameter int FLAG_WIDTH = 16
) (
    input  logic [3:0]            cond,
    input  logic [FLAG_WIDTH-1:0] psr_flags,
    output logic                  taken
);

    logic c, l, f, z, n;
    logic unused_flags;

    assign c = psr_flags[FLAG_C];
    assign l = psr_flags[FLAG_L];
    assign f = psr_flags[FLAG_F];
    assign z = psr_flags[FLAG_Z];
    assign n = psr_flags[FLAG_N];
    assign unused_flags = ^{psr_flags[FLAG_WIDTH-1:8], psr_flags[4:3], psr_flags[1]};

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_EQ:   taken = z;
            CC_NE:   taken = !z;
            CC_CS:   taken = c;
            CC_CC:   taken = !c;
            CC_HI:   taken = l;
            CC_LS:   taken = !l;
            CC_GT:   taken = n;
            CC_LE:   taken = !n;
            CC_FS:   taken = f;
            CC_FC:   taken = !f;
            CC_LO:   taken = !l && !z;
            CC_HS:   taken = l || z;
            CC_LT:   taken = !n && !z;
            CC_GE:   taken = n || z;
            CC_UC:   taken = 1'b1;
            CC_NV:   taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit for the CR16-style datapath: fetch, decode, execute,
// load/store and branch sequencing with registered control strobes.
import bananachine_pkg::*;

module control_fsm #(
    parameter int MEM_LATENCY = 1,
    parameter int FLAG_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            op_code,
    input  logic [3:0]            ext_op_code,
    input  logic [3:0]            A_index,
    input  logic [FLAG_WIDTH-1:0] psr_flags,
    output logic                  ir_en,
    output logic                  pc_en,
    output logic                  pc_src,
    output logic                  mem_addr_src,
    output logic                  wren_a,
    output logic                  reg_write,
    output logic [1:0]            reg_write_src,
    output logic                  alu_A_src,
    output logic                  alu_B_src,
    output logic [5:0]            alu_cont,
    output logic                  psr_en,
    output state_t                state
);

    localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

    logic [1:0] wait_cnt;
    logic       started;
    ctrl_t      ctrl_q;
    ctrl_t      dec_ctrl;
    ctrl_t      wb_ctrl;
    state_t     dec_state;
    logic       taken;

    cond_eval #(.FLAG_WIDTH(FLAG_WIDTH)) u_cond_eval (
        .cond      (A_index),
        .psr_flags (psr_flags),
        .taken     (taken)
    );

    // Strobes for the state entered from DECODE. The PSR can only change at the
    // end of an EXECUTE, so flags seen at this edge equal those in BRANCH.
    always_comb begin
        dec_state = EXECUTE;
        dec_ctrl  = '0;
        if (op_code == OP_SPECIAL && ext_op_code == EXT_LOAD) begin
            dec_state             = LD_ADDR;
            dec_ctrl.mem_addr_src = 1'b1;
            dec_ctrl.alu_cont     = ALU_PASSB;
        end else if (op_code == OP_SPECIAL && ext_op_code == EXT_STOR) begin
            dec_state             = STORE;
            dec_ctrl.mem_addr_src = 1'b1;
            dec_ctrl.alu_cont     = ALU_PASSB;
            dec_ctrl.wren_a       = 1'b1;
            dec_ctrl.pc_en        = 1'b1;
        end else if (op_code == OP_BCOND ||
                     (op_code == OP_SPECIAL && ext_op_code == EXT_JCOND)) begin
            dec_state       = BRANCH;
            dec_ctrl.pc_en  = 1'b1;
            dec_ctrl.pc_src = taken;
            if (op_code == OP_BCOND) begin
                dec_ctrl.alu_B_src = 1'b1;
                dec_ctrl.alu_cont  = ALU_ADD;
            end else begin
                dec_ctrl.alu_cont  = ALU_PASSB;
            end
        end else begin
            dec_ctrl.pc_en     = 1'b1;
            dec_ctrl.alu_A_src = 1'b1;
            unique case (op_code)
                OP_RTYPE: begin
                    dec_ctrl.alu_cont  = {2'b00, ext_op_code};
                    dec_ctrl.psr_en    = ext_op_code inside {EXT_ADD, EXT_SUB, EXT_CMP};
                    dec_ctrl.reg_write = rtype_defined(ext_op_code) && (ext_op_code != EXT_CMP);
                end
                OP_SPECIAL: begin
                    if (ext_op_code == EXT_JAL) begin
                        dec_ctrl.reg_write     = 1'b1;
                        dec_ctrl.reg_write_src = 2'd2;
                        dec_ctrl.alu_cont      = ALU_PASSB;
                        dec_ctrl.pc_src        = 1'b1;
                    end else begin
                        dec_ctrl.alu_cont      = ALU_NOP;
                    end
                end
                OP_MOVI: begin
                    dec_ctrl.alu_cont  = ALU_PASSB;
                    dec_ctrl.alu_A_src = 1'b0;
                    dec_ctrl.alu_B_src = 1'b1;
                    dec_ctrl.reg_write = 1'b1;
                end
                default: begin
                    dec_ctrl.alu_cont  = {2'b01, op_code};
                    dec_ctrl.alu_B_src = 1'b1;
                    dec_ctrl.psr_en    = op_code inside {OP_ADDI, OP_SUBI, OP_CMPI};
                    dec_ctrl.reg_write = (op_code != OP_CMPI);
                end
            endcase
        end
    end

    always_comb begin
        wb_ctrl               = '0;
        wb_ctrl.reg_write     = 1'b1;
        wb_ctrl.reg_write_src = 2'd1;
        wb_ctrl.pc_en         = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            started  <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            ctrl_q <= '0;
            unique case (state)
                FETCH: begin
                    // First edge after reset release only arms the sequencer,
                    // so the first FETCH occupies a full cycle.
                    if (started) begin
                        state        <= FETCH_WAIT;
                        wait_cnt     <= LAT_LAST;
                        ctrl_q.ir_en <= (LAT_LAST == 2'd0);
                    end else begin
                        started <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= DECODE;
                    end else begin
                        wait_cnt     <= wait_cnt - 2'd1;
                        ctrl_q.ir_en <= (wait_cnt == 2'd1);
                    end
                end
                DECODE: begin
                    state  <= dec_state;
                    ctrl_q <= dec_ctrl;
                end
                LD_ADDR: begin
                    state    <= LD_WAIT;
                    wait_cnt <= LAT_LAST;
                    ctrl_q   <= ctrl_q;
                end
                LD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state  <= LD_WB;
                        ctrl_q <= wb_ctrl;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                        ctrl_q   <= ctrl_q;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign ir_en         = ctrl_q.ir_en;
    assign pc_en         = ctrl_q.pc_en;
    assign pc_src        = ctrl_q.pc_src;
    assign mem_addr_src  = ctrl_q.mem_addr_src;
    assign wren_a        = ctrl_q.wren_a;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_write_src = ctrl_q.reg_write_src;
    assign alu_A_src     = ctrl_q.alu_A_src;
    assign alu_B_src     = ctrl_q.alu_B_src;
    assign alu_cont      = ctrl_q.alu_cont;
    assign psr_en        = ctrl_q.psr_en;

endmodule
